// File: rtl/exc_ctrl.sv
// Exception sequencer in front of CP0: qualifies ID trap/eret requests, commits them
// to CP0, flushes the pipeline for a fixed time, then redirects the PC once.
module exc_ctrl #(
   parameter int unsigned FLUSH_CYCLES  = 2,
   parameter logic [4:0]  CAUSE_SYSCALL = 5'd8,
   parameter logic [4:0]  CAUSE_BREAK   = 5'd9,
   parameter logic [4:0]  CAUSE_TEQ     = 5'd13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic        is_syscall,
   input  logic        is_break,
   input  logic        is_teq,
   input  logic        teq_eq,
   input  logic        is_eret,
   input  logic [31:0] status,
   input  logic [31:0] exc_addr,
   output logic        exception,
   output logic        eret,
   output logic [4:0]  cause,
   output logic [31:0] exc_pc,
   output logic        flush,
   output logic        pc_redirect,
   output logic [31:0] redirect_pc,
   output logic        busy
);
   // state      | meaning
   // S_IDLE     | waiting for a qualified ID request
   // S_COMMIT   | one-cycle exception/eret pulse to CP0, flush asserted
   // S_FLUSH    | pipeline flush, counter runs down to 0
   // S_REDIRECT | one-cycle PC load to the latched target
   typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_FLUSH, S_REDIRECT} state_t;

   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [4:0]  cause_q;
   logic [31:0] pc_q;
   logic [31:0] target_q;
   logic        eret_q;

   logic        take_eret, take_sys, take_brk, take_teq, take;
   logic [4:0]  cause_nxt;
   logic        unused_status;

   assign unused_status = ^status[31:4];

   assign take_eret = is_eret;
   assign take_sys  = is_syscall & status[0] & status[1];
   assign take_brk  = is_break & status[0] & status[2];
   assign take_teq  = is_teq & teq_eq & status[0] & status[3];
   assign take      = id_valid & ~stall & (take_eret | take_sys | take_brk | take_teq);

   always_comb begin
      cause_nxt = 5'd0;
      if (take_eret)     cause_nxt = 5'd0;
      else if (take_sys) cause_nxt = CAUSE_SYSCALL;
      else if (take_brk) cause_nxt = CAUSE_BREAK;
      else if (take_teq) cause_nxt = CAUSE_TEQ;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (take) state_nxt = S_COMMIT;
         S_COMMIT:   state_nxt = S_FLUSH;
         S_FLUSH:    if (cnt == 4'd0) state_nxt = S_REDIRECT;
         S_REDIRECT: state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= 4'd0;
         cause_q  <= 5'd0;
         pc_q     <= 32'd0;
         target_q <= 32'd0;
         eret_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (take) begin
               cause_q <= cause_nxt;
               pc_q    <= id_pc;
               eret_q  <= take_eret;
            end
            // CP0 already sees the commit pulse here, so exc_addr is EPC for eret
            S_COMMIT: begin
               target_q <= exc_addr;
               cnt      <= FLUSH_LAST;
            end
            S_FLUSH:  if (cnt != 4'd0) cnt <= cnt - 4'd1;
            default:  ;
         endcase
      end
   end

   always_comb begin
      exception   = 1'b0;
      eret        = 1'b0;
      flush       = 1'b0;
      pc_redirect = 1'b0;
      busy        = 1'b1;
      case (state)
         S_IDLE:     busy = 1'b0;
         S_COMMIT: begin
            exception = ~eret_q;
            eret      = eret_q;
            flush     = 1'b1;
         end
         S_FLUSH:    flush = 1'b1;
         S_REDIRECT: pc_redirect = 1'b1;
         default:    busy = 1'b0;
      endcase
   end

   assign cause       = cause_q;
   assign exc_pc      = pc_q;
   assign redirect_pc = target_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: vector table, hand-written corner sequences and a
// randomized run, all checked against a time-based reference model.
module tb_exc_ctrl;
   localparam int F = 2;

   logic        clk, rst, stall, id_valid, is_syscall, is_break, is_teq, teq_eq, is_eret;
   logic [31:0] id_pc, status, exc_addr;
   logic        exception, eret, flush, pc_redirect, busy;
   logic [4:0]  cause;
   logic [31:0] exc_pc, redirect_pc;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: mt = cycles elapsed since the sample edge (0 = idle)
   int          mt;
   logic        m_eret;
   logic [4:0]  m_cause;
   logic [31:0] m_pc, m_target;

   exc_ctrl #(.FLUSH_CYCLES(F)) dut (
      .clk(clk), .rst(rst), .stall(stall), .id_valid(id_valid), .id_pc(id_pc),
      .is_syscall(is_syscall), .is_break(is_break), .is_teq(is_teq), .teq_eq(teq_eq),
      .is_eret(is_eret), .status(status), .exc_addr(exc_addr),
      .exception(exception), .eret(eret), .cause(cause), .exc_pc(exc_pc),
      .flush(flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        vld, sys, brk, teq, eq, ert;
      logic [31:0] st;
      logic        exp_exc, exp_eret;
      logic [4:0]  exp_cause;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // returns 1 if the current inputs form a qualified request; sets cause and kind
   function automatic logic qualify(output logic [4:0] c, output logic k);
      c = 5'd0; k = 1'b0;
      if (!id_valid || stall) return 1'b0;
      if (is_eret) begin k = 1'b1; return 1'b1; end
      if (is_syscall && status[0] && status[1]) begin c = 5'd8; return 1'b1; end
      if (is_break && status[0] && status[2]) begin c = 5'd9; return 1'b1; end
      if (is_teq && teq_eq && status[0] && status[3]) begin c = 5'd13; return 1'b1; end
      return 1'b0;
   endfunction

   task automatic model_reset();
      mt = 0; m_eret = 0; m_cause = 0; m_pc = 0; m_target = 0;
   endtask

   task automatic check_all();
      chk("exception",   32'(exception),   32'(mt == 1 && !m_eret));
      chk("eret",        32'(eret),        32'(mt == 1 && m_eret));
      chk("cause",       32'(cause),       32'(m_cause));
      chk("exc_pc",      exc_pc,           m_pc);
      chk("flush",       32'(flush),       32'(mt >= 1 && mt <= F + 1));
      chk("pc_redirect", 32'(pc_redirect), 32'(mt == F + 2));
      chk("redirect_pc", redirect_pc,      (mt == F + 2) ? m_target : redirect_pc);
      chk("busy",        32'(busy),        32'(mt != 0));
   endtask

   task automatic tick();
      logic [4:0] c;
      logic       k;
      if (mt == 0) begin
         if (qualify(c, k)) begin
            mt = 1; m_cause = c; m_eret = k; m_pc = id_pc;
         end
      end else if (mt == F + 2) begin
         mt = 0;
      end else begin
         if (mt == 1) m_target = exc_addr;
         mt++;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic clear_req();
      id_valid = 1; stall = 0; is_syscall = 0; is_break = 0; is_teq = 0; teq_eq = 0; is_eret = 0;
   endtask

   initial begin
      int pulses;
      vecs[0]  = '{1,1,0,0,0,0, 32'h0000000f, 1,0, 5'd8};
      vecs[1]  = '{1,0,1,0,0,0, 32'h000001e0, 0,0, 5'd0};
      vecs[2]  = '{1,0,0,1,0,0, 32'h0000000f, 0,0, 5'd0};
      vecs[3]  = '{1,0,0,1,1,0, 32'h0000000f, 1,0, 5'd13};
      vecs[4]  = '{1,1,1,0,0,0, 32'h0000000f, 1,0, 5'd8};
      vecs[5]  = '{1,1,1,1,1,1, 32'h0000000f, 0,1, 5'd0};
      vecs[6]  = '{1,1,0,0,0,0, 32'h00000003, 1,0, 5'd8};
      vecs[7]  = '{1,1,0,0,0,0, 32'h00000002, 0,0, 5'd0};
      vecs[8]  = '{1,0,1,0,0,0, 32'h00000005, 1,0, 5'd9};
      vecs[9]  = '{0,1,0,0,0,0, 32'h0000000f, 0,0, 5'd0};
      vecs[10] = '{1,0,0,0,0,1, 32'h00000000, 0,1, 5'd0};
      vecs[11] = '{1,0,1,1,1,0, 32'h0000000b, 1,0, 5'd13};

      rst = 0; clear_req(); id_pc = 0; status = 0; exc_addr = 0;
      model_reset();
      #12;
      check_all();
      @(negedge clk); rst = 1;
      tick();

      // table vectors, one request from idle each
      for (int i = 0; i < 12; i++) begin
         id_valid = vecs[i].vld; is_syscall = vecs[i].sys; is_break = vecs[i].brk;
         is_teq = vecs[i].teq; teq_eq = vecs[i].eq; is_eret = vecs[i].ert;
         status = vecs[i].st; id_pc = 32'h00400000 + 32'(i * 4);
         exc_addr = 32'h80000000 + 32'(i * 16);
         tick();
         chk($sformatf("vec%0d_exception", i), 32'(exception), 32'(vecs[i].exp_exc));
         chk($sformatf("vec%0d_eret", i), 32'(eret), 32'(vecs[i].exp_eret));
         if (vecs[i].exp_exc || vecs[i].exp_eret) begin
            chk($sformatf("vec%0d_cause", i), 32'(cause), 32'(vecs[i].exp_cause));
            chk($sformatf("vec%0d_exc_pc", i), exc_pc, id_pc);
         end else
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
         clear_req();
         for (int j = 0; j < F + 2; j++) tick();
      end

      // syscall timeline with handler address
      status = 32'h0000000f; id_pc = 32'h00400010; is_syscall = 1; exc_addr = 32'h80000180;
      tick();
      chk("sys_exc_n", 32'(exception), 32'd1);
      chk("sys_cause_n", 32'(cause), 32'd8);
      clear_req();
      tick(); tick();
      chk("sys_flush_n2", 32'(flush), 32'd1);
      tick();
      chk("sys_redirect_n3", 32'(pc_redirect), 32'd1);
      chk("sys_redirect_pc", redirect_pc, 32'h80000180);
      chk("sys_flush_n3", 32'(flush), 32'd0);
      tick();

      // eret: EPC presented only while eret=1
      is_eret = 1; id_pc = 32'h00400100; exc_addr = 32'hdeadbeef;
      tick();
      chk("eret_pulse", 32'(eret), 32'd1);
      chk("eret_no_exc", 32'(exception), 32'd0);
      clear_req(); exc_addr = 32'h00400014;
      tick();
      exc_addr = 32'h11111111;
      chk("eret_1cyc", 32'(eret), 32'd0);
      tick(); tick();
      chk("eret_redirect_pc", redirect_pc, 32'h00400014);
      chk("eret_redirect", 32'(pc_redirect), 32'd1);
      tick();

      // second syscall while busy is ignored
      is_syscall = 1; id_pc = 32'h00400200; pulses = 0;
      for (int j = 0; j < F + 3; j++) begin
         tick();
         if (exception) pulses++;
      end
      chk("busy_single_pulse", 32'(pulses), 32'd1);
      clear_req();
      tick();

      // stall at request edge
      is_syscall = 1; stall = 1; id_pc = 32'h00400300;
      tick();
      chk("stall_no_exc", 32'(exception), 32'd0);
      tick();
      stall = 0;
      tick();
      chk("stall_release_exc", 32'(exception), 32'd1);
      clear_req();
      for (int j = 0; j < F + 2; j++) tick();

      // async reset during flush
      is_break = 1; status = 32'h5; id_pc = 32'h00400400; exc_addr = 32'h80000200;
      tick();
      clear_req();
      tick();
      chk("rst_in_flush", 32'(flush), 32'd1);
      #3 rst = 0;
      #1 model_reset();
      check_all();
      chk("rst_cause", 32'(cause), 32'd0);
      @(negedge clk); rst = 1;
      pulses = 0;
      for (int j = 0; j < F + 3; j++) begin
         tick();
         if (pc_redirect) pulses++;
      end
      chk("rst_no_redirect", 32'(pulses), 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         id_valid   = ($urandom_range(0, 7) != 0);
         stall      = ($urandom_range(0, 3) == 0);
         is_syscall = ($urandom_range(0, 5) == 0);
         is_break   = ($urandom_range(0, 5) == 0);
         is_teq     = ($urandom_range(0, 5) == 0);
         teq_eq     = $urandom_range(0, 1);
         is_eret    = ($urandom_range(0, 11) == 0);
         status     = {$urandom_range(0, 32'hffff), 12'h0, 4'($urandom_range(0, 15))};
         id_pc      = $urandom;
         exc_addr   = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
